// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory access unit.
//   - access size encodings as seen on the CPU load/store port
//   - FSM state enum for dmem_access_unit
//   - default data-segment base address and memory depth, shared with the
//     top-level address map
//   - helper that classifies a size/low-offset pair as misaligned or illegal
package dmem_pkg;

    localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;
    localparam int          DMEM_DEPTH     = 2048;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_ISSUE,
        ST_LD_DATA,
        ST_RMW_RD,
        ST_RMW_MERGE,
        ST_WRITE,
        ST_ERR
    } state_e;

    // True when the size code is illegal or the offset is not naturally
    // aligned for that size.
    function automatic logic size_align_bad(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_HALF: return off[0];
            SZ_WORD: return (off != 2'b00);
            SZ_ILL:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: CPU load/store port plus word-memory port.
//   CPU side : req_valid/req_we/req_size/req_signed/req_addr/req_wdata in,
//              ready/done/err/rdata out
//   Mem side : mem_cs/mem_r/mem_w/mem_addr/mem_wdata out, mem_rdata in
// Modports:
//   slave  - the access unit's view
//   master - the environment's view (CPU plus memory)
interface dmem_access_unit_if #(
    parameter int AW = 11
) ();

    logic          req_valid;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          ready;
    logic          done;
    logic          err;
    logic [31:0]   rdata;

    logic          mem_cs;
    logic          mem_r;
    logic          mem_w;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output ready, done, err, rdata,
        output mem_cs, mem_r, mem_w, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  ready, done, err, rdata,
        input  mem_cs, mem_r, mem_w, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: combinational little-endian lane formatting.
//   i_word   - word read from memory
//   i_off    - byte offset within the word
//   i_size   - access size
//   i_signed - sign-extend (1) or zero-extend (0) sub-word loads
//   i_new    - right-justified store data
//   o_ext    - extracted and extended load value
//   o_merged - i_word with the addressed lane replaced by i_new
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  size_e       i_size,
    input  logic        i_signed,
    input  logic [31:0] i_new,
    output logic [31:0] o_ext,
    output logic [31:0] o_merged
);

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                            input size_e sz, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (sz)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [1:0] off, input size_e sz);
        logic [31:0] r;
        r = old;
        case (sz)
            SZ_BYTE: r[{off, 3'b000} +: 8]     = nw[7:0];
            SZ_HALF: r[{off[1], 4'b0000} +: 16] = nw[15:0];
            default: r = nw;
        endcase
        return r;
    endfunction

    assign o_ext    = extract(i_word, i_off, i_size, i_signed);
    assign o_merged = merge(i_word, i_new, i_off, i_size);

endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: multi-cycle bridge from the CPU load/store port to the
// word-organised data memory.
//   clk_in - clock, rising edge
//   reset  - asynchronous active-low reset
//   bus    - dmem_access_unit_if.slave (CPU request/response + memory port)
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | ready=1, waiting for a request
// ST_LD_ISSUE  | read strobe for a load
// ST_LD_DATA   | memory data valid; extract, extend, done
// ST_RMW_RD    | read strobe for a sub-word store
// ST_RMW_MERGE | old word valid; merge new lane into merge buffer
// ST_WRITE     | write strobe (word data or merge buffer), done
// ST_ERR       | rejected access: done+err, no strobes
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DMEM_BASE_ADDR,
    parameter int          DEPTH     = DMEM_DEPTH
) (
    input  logic               clk_in,
    input  logic               reset,
    dmem_access_unit_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    state_e        r_state;
    state_e        w_state_nxt;
    logic          r_we;
    size_e         r_size;
    logic          r_signed;
    logic [31:0]   r_wdata;
    // Only the in-range offset bits matter after acceptance; everything above
    // is checked before the access leaves IDLE.
    logic [AW+1:0] r_off;
    logic [31:0]   r_merge;
    logic [31:0]   r_rdata;

    logic [31:0]   w_off;
    logic          w_reject;
    logic          w_accept;
    size_e         w_req_size;
    logic [31:0]   w_ext;
    logic [31:0]   w_merged;
    logic          w_rd;
    logic          w_wr;

    assign w_req_size = size_e'(bus.req_size);
    assign w_off      = bus.req_addr - BASE_ADDR;
    // Addresses below the base wrap to huge offsets and fail the range test.
    assign w_reject   = size_align_bad(w_req_size, w_off[1:0]) ||
                        (w_off >= 32'(DEPTH * 4));
    assign w_accept   = (r_state == ST_IDLE) && bus.req_valid;

    dmem_lane_fmt u_lane_fmt (
        .i_word   (bus.mem_rdata),
        .i_off    (r_off[1:0]),
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_new    (r_wdata),
        .o_ext    (w_ext),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (w_reject) begin
                        w_state_nxt = ST_ERR;
                    end else if (!bus.req_we) begin
                        w_state_nxt = ST_LD_ISSUE;
                    end else if (w_req_size == SZ_WORD) begin
                        w_state_nxt = ST_WRITE;
                    end else begin
                        w_state_nxt = ST_RMW_RD;
                    end
                end
            end
            ST_LD_ISSUE:  w_state_nxt = ST_LD_DATA;
            ST_LD_DATA:   w_state_nxt = ST_IDLE;
            ST_RMW_RD:    w_state_nxt = ST_RMW_MERGE;
            ST_RMW_MERGE: w_state_nxt = ST_WRITE;
            ST_WRITE:     w_state_nxt = ST_IDLE;
            ST_ERR:       w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_we     <= 1'b0;
            r_size   <= SZ_BYTE;
            r_signed <= 1'b0;
            r_wdata  <= '0;
            r_off    <= '0;
            r_merge  <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_accept) begin
                r_we     <= bus.req_we;
                r_size   <= w_req_size;
                r_signed <= bus.req_signed;
                r_wdata  <= bus.req_wdata;
                r_off    <= w_off[AW+1:0];
            end
            if (r_state == ST_RMW_MERGE) begin
                r_merge <= w_merged;
            end
            if (r_state == ST_LD_DATA) begin
                r_rdata <= w_ext;
            end
        end
    end

    // All outputs decode from the state register so they fall together with
    // an asynchronous reset.
    assign w_rd = (r_state == ST_LD_ISSUE) || (r_state == ST_RMW_RD);
    assign w_wr = (r_state == ST_WRITE);

    assign bus.ready     = (r_state == ST_IDLE);
    assign bus.done      = (r_state == ST_LD_DATA) || (r_state == ST_WRITE) ||
                           (r_state == ST_ERR);
    assign bus.err       = (r_state == ST_ERR);
    // Present the load result in the done cycle itself; the register holds
    // it afterwards.
    assign bus.rdata     = (r_state == ST_LD_DATA) ? w_ext : r_rdata;
    assign bus.mem_r     = w_rd;
    assign bus.mem_w     = w_wr;
    assign bus.mem_cs    = w_rd | w_wr;
    assign bus.mem_addr  = (w_rd | w_wr) ? r_off[AW+1:2] : '0;
    assign bus.mem_wdata = !w_wr              ? 32'h0   :
                           (r_size == SZ_WORD) ? r_wdata : r_merge;

    // r_we steers the FSM only at acceptance; keep it latched for visibility.
    logic w_unused;
    assign w_unused = r_we;

endmodule
